// File: rtl/operand_seq.sv
// Operand sequencer: collects A then B (with op select), drives an external
// adder/subtractor, captures its result and holds it until downstream takes it.
// Build option: OPSEQ_FLAGS_EN enables the zero and carry/borrow flags.
module operand_seq #(
   parameter int dw = 8
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          in_valid,
   input  logic [dw-1:0] in_data,
   input  logic          in_op,
   output logic          in_ready,
   output logic [dw-1:0] dataa,
   output logic [dw-1:0] datab,
   output logic          add_sub,
   input  logic [dw-1:0] result,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [dw-1:0] out_data,
   output logic          flag_z,
   output logic          flag_c,
   output logic [7:0]    op_count
);

   typedef enum logic [1:0] {LOAD_A, LOAD_B, EXEC, HOLD} state_e;

   state_e        state_q, state_d;
   logic [dw-1:0] dataa_q, datab_q, out_data_q;
   logic          add_sub_q;
   logic [7:0]    op_count_q;
   logic          in_xfer, out_xfer;

   assign in_xfer  = in_valid & in_ready;
   assign out_xfer = out_valid & out_ready;

   always_ff @(posedge clk) begin
      if (!reset_n) state_q <= LOAD_A;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         LOAD_A:  if (in_xfer)  state_d = LOAD_B;
         LOAD_B:  if (in_xfer)  state_d = EXEC;
         EXEC:                  state_d = HOLD;
         HOLD:    if (out_xfer) state_d = LOAD_A;
         default:               state_d = LOAD_A;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == LOAD_A) || (state_q == LOAD_B);
      out_valid = (state_q == HOLD);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         dataa_q    <= '0;
         datab_q    <= '0;
         add_sub_q  <= 1'b1;
         out_data_q <= '0;
         op_count_q <= 8'd0;
      end else begin
         if (in_xfer && state_q == LOAD_A) dataa_q <= in_data;
         if (in_xfer && state_q == LOAD_B) begin
            datab_q   <= in_data;
            add_sub_q <= in_op;
         end
         if (state_q == EXEC) out_data_q <= result;
         if (out_xfer)        op_count_q <= op_count_q + 8'd1;
      end
   end

`ifdef OPSEQ_FLAGS_EN
   logic          flag_z_q, flag_c_q, carry_d;
   logic [dw:0]   sum_ext;

   // Carry and borrow come from the operands, not the returned result.
   assign sum_ext = {1'b0, dataa_q} + {1'b0, datab_q};
   assign carry_d = add_sub_q ? sum_ext[dw] : (dataa_q < datab_q);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         flag_z_q <= 1'b0;
         flag_c_q <= 1'b0;
      end else if (state_q == EXEC) begin
         flag_z_q <= (result == '0);
         flag_c_q <= carry_d;
      end
   end

   assign flag_z = flag_z_q;
   assign flag_c = flag_c_q;
`else
   assign flag_z = 1'b0;
   assign flag_c = 1'b0;
`endif

   assign dataa    = dataa_q;
   assign datab    = datab_q;
   assign add_sub  = add_sub_q;
   assign out_data = out_data_q;
   assign op_count = op_count_q;

endmodule

// File: tb/tb_operand_seq.sv
// Scoreboard bench for operand_seq: a driver issues A/B words and queues the
// expected result, a monitor pops and compares on each output handshake.
module tb_operand_seq;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          in_valid = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          in_op = 1'b0;
   logic          in_ready;
   logic [DW-1:0] dataa, datab, result, out_data;
   logic          add_sub, out_valid, flag_z, flag_c;
   logic          out_ready = 1'b0;
   logic [7:0]    op_count;

   int checks = 0;
   int failures = 0;
   int rdy_mode = 2;            // 0 random, 1 always ready, 2 never ready
   logic [7:0] exp_cnt = 8'd0;

   typedef struct { logic [DW-1:0] data; logic z; logic c; } exp_t;
   exp_t sb[$];

   operand_seq #(.dw(DW)) dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
      .in_op(in_op), .in_ready(in_ready), .dataa(dataa), .datab(datab),
      .add_sub(add_sub), .result(result), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .flag_z(flag_z),
      .flag_c(flag_c), .op_count(op_count)
   );

   // External adder/subtractor the block is meant to drive.
   assign result = add_sub ? dataa + datab : dataa - datab;

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic op);
      exp_t e;
      int   full;
      full   = op ? int'(a) + int'(b) : int'(a) - int'(b);
      e.data = full[7:0];
`ifdef OPSEQ_FLAGS_EN
      e.z = (e.data == 8'd0);
      e.c = op ? (full > 255) : (full < 0);
`else
      e.z = 1'b0;
      e.c = 1'b0;
`endif
      return e;
   endfunction

   // Callers are always positioned 1 time unit after a rising edge.
   task automatic send(input logic [7:0] d, input logic op);
      bit ok = 0;
      in_valid = 1'b1; in_data = d; in_op = op;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (in_ready) begin ok = 1; break; end
      end
      if (!ok) chk("send_timeout", 0, 1);
      @(posedge clk); #1;
      in_valid = 1'b0; in_data = 8'($urandom); in_op = 1'($urandom);
   endtask

   task automatic txn(input logic [7:0] a, input logic [7:0] b, input logic op);
      send(a, 1'($urandom));
      send(b, op);
      sb.push_back(model(a, b, op));
   endtask

   task automatic wait_drain();
      bit ok = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (sb.size() == 0) begin ok = 1; break; end
      end
      if (!ok) chk("drain_timeout", 0, 1);
      @(negedge clk);
      @(posedge clk); #1;
   endtask

   task automatic wait_out_valid();
      bit ok = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (out_valid) begin ok = 1; break; end
      end
      if (!ok) chk("out_valid_timeout", 0, 1);
      @(posedge clk); #1;
   endtask

   task automatic pulse_reset();
      reset_n = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
   endtask

   task automatic chk_reset_state(input string tag);
      @(negedge clk);
      chk({tag, "_in_ready"}, in_ready, 1);
      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_dataa"}, dataa, 0);
      chk({tag, "_datab"}, datab, 0);
      chk({tag, "_add_sub"}, add_sub, 1);
      chk({tag, "_out_data"}, out_data, 0);
      chk({tag, "_flags"}, {flag_z, flag_c}, 0);
      chk({tag, "_op_count"}, op_count, 0);
      @(posedge clk); #1;
   endtask

   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0:       out_ready = 1'($urandom);
         1:       out_ready = 1'b1;
         default: out_ready = 1'b0;
      endcase
   end

   // Monitor: a handshake seen at the falling edge completes on the next rising edge.
   initial begin
      bit   pend = 0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            sb.delete(); exp_cnt = 8'd0; pend = 0;
         end else begin
            if (pend) begin
               chk("op_count", op_count, exp_cnt);
               pend = 0;
            end
            if (out_valid && out_ready) begin
               if (sb.size() == 0) chk("unexpected_output", 1, 0);
               else begin
                  e = sb.pop_front();
                  chk("out_data", out_data, e.data);
                  chk("flag_z", flag_z, e.z);
                  chk("flag_c", flag_c, e.c);
               end
               exp_cnt = exp_cnt + 8'd1;
               pend = 1;
            end
         end
      end
   end

   initial begin
      logic [7:0] hold_data;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      chk_reset_state("por");

      // Reset while waiting for B
      rdy_mode = 1;
      send(8'h44, 1'b0);
      pulse_reset();
      chk_reset_state("rst_loadb");

      // Reset while a result is pending in HOLD
      rdy_mode = 2;
      send(8'h12, 1'b0);
      send(8'h34, 1'b0);
      wait_out_valid();
      pulse_reset();
      chk_reset_state("rst_hold");

      // Basic add with latency check
      rdy_mode = 1;
      txn(8'h05, 8'h03, 1'b1);
      @(negedge clk); chk("lat_exec_valid", out_valid, 0);
      @(negedge clk); chk("lat_hold_valid", out_valid, 1);
      chk("lat_out_data", out_data, 8'h08);
      @(negedge clk); chk("lat_after_valid", out_valid, 0);
      chk("lat_op_count", op_count, 1);
      @(posedge clk); #1;

      txn(8'hF0, 8'h20, 1'b1);
      txn(8'h03, 8'h05, 1'b0);
      txn(8'h07, 8'h07, 1'b0);
      txn(8'hFF, 8'h01, 1'b1);
      txn(8'h00, 8'h01, 1'b0);
      wait_drain();

      // Backpressure: result held, inputs ignored
      rdy_mode = 2;
      txn(8'h11, 8'h22, 1'b1);
      wait_out_valid();
      hold_data = out_data;
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1; in_data = (i % 2) ? 8'hAA : 8'h55;
         @(negedge clk);
         chk("bp_in_ready", in_ready, 0);
         chk("bp_out_data", out_data, hold_data);
         chk("bp_operands", {dataa, datab}, 16'h1122);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      rdy_mode = 1;
      wait_drain();

      // Random traffic with random backpressure
      rdy_mode = 0;
      for (int i = 0; i < 40; i++) txn(8'($urandom), 8'($urandom), 1'($urandom));
      rdy_mode = 1;
      wait_drain();

      // op_count wrap
      pulse_reset();
      chk_reset_state("rst_wrap");
      for (int i = 1; i <= 256; i++) begin
         txn(8'($urandom), 8'($urandom), 1'($urandom));
         if (i == 255) begin
            wait_drain();
            chk("wrap_255", op_count, 8'hFF);
         end
      end
      wait_drain();
      chk("wrap_256", op_count, 8'h00);
      chk("sb_empty", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end
endmodule
